// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO with fill level, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
//
// Optional build macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through, where
// r_data always shows the head word. Left undefined, r_data is a registered read
// with one cycle of latency after an accepted r_en.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   w_en, w_data  write request and data; rejected while full
//   r_en, r_data  read request and data; rejected while empty
//   full, empty, almost_full, almost_empty, level
//                 registered status, all derived from the updated level
//   overflow, underflow
//                 sticky error flags: write while full / read while empty
//   clr_err       synchronous clear of both error flags; a same-edge set wins
module sync_fifo_ctl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_en,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       r_en,
  output logic [WIDTH-1:0]           r_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);
  localparam logic [LW-1:0] LvlAf   = LW'(AF_THRESH);
  localparam logic [LW-1:0] LvlAe   = LW'(AE_THRESH);
  localparam logic [PW-1:0] PtrOne  = PW'(1);
  localparam logic [LW-1:0] LvlOne  = LW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic             full_q, empty_q, af_q, ae_q;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  always_comb begin
    // Accept decisions use the flags registered before this edge.
    wr_acc = w_en & ~full_q;
    rd_acc = r_en & ~empty_q;

    wptr_d = wr_acc ? wptr_q + PtrOne : wptr_q;
    rptr_d = rd_acc ? rptr_q + PtrOne : rptr_q;

    level_d = level_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase

`ifdef SYNC_FIFO_FWFT_EN
    // Register the head word for the next cycle. When the new head is the word
    // being written right now, memory does not hold it yet, so bypass w_data.
    r_data_d = r_data_q;
    if (level_d != '0) begin
      if (wr_acc && (wptr_q == rptr_d)) begin
        r_data_d = w_data;
      end else begin
        r_data_d = mem_q[rptr_d];
      end
    end
`else
    r_data_d = rd_acc ? mem_q[rptr_q] : r_data_q;
`endif

    // Set takes priority over clear on the same edge.
    overflow_d  = (w_en & full_q)  | (overflow_q  & ~clr_err);
    underflow_d = (r_en & empty_q) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      r_data_q    <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      r_data_q    <= r_data_d;
      full_q      <= (level_d == LvlFull);
      empty_q     <= (level_d == '0);
      af_q        <= (level_d >= LvlAf);
      ae_q        <= (level_d <= LvlAe);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= w_data;
    end
  end

  assign r_data       = r_data_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
module tb_sync_fifo_ctl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int          AF    = DEPTH - 2;
  localparam int          AE    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             w_en = 1'b0;
  logic [WIDTH-1:0] w_data = '0;
  logic             r_en = 1'b0;
  logic [WIDTH-1:0] r_data;
  logic             full, empty, almost_full, almost_empty;
  logic [LW-1:0]    level;
  logic             overflow, underflow;
  logic             clr_err = 1'b0;

  sync_fifo_ctl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w_en         (w_en),
    .w_data       (w_data),
    .r_en         (r_en),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents, expected-read scoreboard and error flags.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_rdata = '0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    int lvl;
    lvl = m_q.size();
    check("level",        32'(level),        32'(lvl));
    check("empty",        32'(empty),        32'(lvl == 0));
    check("full",         32'(full),         32'(lvl == DEPTH));
    check("almost_full",  32'(almost_full),  32'(lvl >= AF));
    check("almost_empty", 32'(almost_empty), 32'(lvl <= AE));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
    check("r_data",       r_data,            m_rdata);
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock of stimulus; model updated from pre-edge state, outputs checked
  // 1 time unit after the edge.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                      input logic c);
    bit is_full, is_empty;
    is_full  = (m_q.size() == DEPTH);
    is_empty = (m_q.size() == 0);
    w_en = w; w_data = d; r_en = r; clr_err = c;
    m_ovf = (w && is_full)  ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = (r && is_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
    if (r && !is_empty) exp_q.push_back(m_q.pop_front());
    if (w && !is_full)  m_q.push_back(d);
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    exp_q.delete();
    if (m_q.size() != 0) m_rdata = m_q[0];
`else
    if (exp_q.size() != 0) m_rdata = exp_q.pop_front();
`endif
    check_status();
  endtask

  initial begin
    // 1. Reset
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_status();
    #3 rst_n = 1'b1;

    // 2. Fill to full, overflow, drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      if (i == AF - 1) check("af_at_thresh", 32'(almost_full), 32'd1);
    end
    check("full_after_fill", 32'(full), 32'd1);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("no_dead", 32'(r_data == 32'hDEAD), 32'd0);
    end
    step(1'b0, '0, 1'b0, 1'b1);

    // 3. Simultaneous read and write at level 5
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, WIDTH'(100 + i), 1'b1, 1'b0);
    check("rw_level", 32'(level), 32'd5);
    while (m_q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);

    // 4. Underflow, clear, and set-wins-over-clear
    step(1'b0, '0, 1'b1, 1'b0);
    check("unf_set", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("unf_clr", 32'(underflow), 32'd0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("unf_set_wins", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // 5. Wrap-around: 3 rounds of 10 in, 10 out
    for (int rd = 0; rd < 3; rd++) begin
      for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(rd * 10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("wrap_empty", 32'(empty), 32'd1);
      check("wrap_level", 32'(level), 32'd0);
    end

    // 6. Reset mid-operation, then no stale data
    for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(200 + i), 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    model_reset();
    check_status();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b1, 32'hA5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_data", r_data, 32'hA5);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_unf", 32'(underflow), 32'd1);

    // Mixed random traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctl.md
Name: sync_fifo_ctl

Overview:
Single-clock, parametrised FIFO, the same-domain companion to async_fifo for paths where producer and consumer share one clock. Adds a fill-level output, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Storage is an internal register array with a registered read port, plus an optional first-word-fall-through mode.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH

Ports:
clk  in  1  clock; all logic is rising-edge
rst_n  in  1  asynchronous active-low reset
w_en  in  1  write request
w_data  in  WIDTH  write data
r_en  in  1  read request
r_data  out  WIDTH  read data
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n=0, async assert, sync release): write pointer, read pointer and level = 0; empty=1, full=0, almost_empty=1, almost_full=0; r_data=0; overflow=underflow=0. Memory contents are not reset.
- Write accept: w_en && !full, sampled at the clock edge. w_data goes to mem[wptr]; wptr increments modulo DEPTH.
- Read accept: r_en && !empty, sampled at the clock edge; rptr increments modulo DEPTH.
- full and empty are the registered values present before the edge. A write while full is rejected even if a read is accepted on the same edge. A read while empty is rejected even if a write is accepted on the same edge.
- Level update per edge: +1 for write only, -1 for read only, 0 for both or neither. It never exceeds DEPTH and never goes below 0.
- All status flags are registered and are a pure function of the updated level. They change on the same edge as level.
- Pointer width is $clog2(DEPTH); wrap is natural. full/empty come from level, not pointer comparison.
- Standard read mode: on an accepted read, r_data <= mem[rptr] at that edge, i.e. 1-cycle latency, valid after the edge at which r_en was sampled. r_data holds its value on all other cycles, including rejected reads.
- overflow is set on any edge with w_en && full; underflow is set on any edge with r_en && empty.
- clr_err clears both error flags. If set and clear occur on the same edge, set wins. The flags have no effect on data flow.
- Asserting rst_n mid-operation discards all contents immediately: empty=1 and level=0 without waiting for a clock.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined: first-word-fall-through. r_data continuously equals mem[rptr] while !empty, so the head word is visible with no r_en. r_en pops the head, and the next word (if any) appears after that edge. A word written at edge N is visible on r_data after edge N if the FIFO was empty. r_data is undefined-but-stable (last head) while empty, and reads 0 after reset.
- Undefined: standard registered read as above.

Test Plan:
1. Reset: rst_n=0 for 3 cycles -> level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, r_data=0.
2. Fill/drain, DEPTH=16, AF=14: write 0..15 on 16 consecutive edges -> almost_full=1 after 14th write, full=1/level=16 after 16th. Extra write 0xDEAD -> overflow=1, level stays 16. Read 16 -> r_data 0..15 in order, empty=1, 0xDEAD never appears.
3. Simultaneous read and write: preload 5 words (0..4), then 6 cycles of w_en=r_en=1 with data 100..105 -> level stays 5; read-out order is 0..4 then 100..105.
4. Underflow/clear: empty FIFO, r_en=1 for 1 cycle -> underflow=1, r_data unchanged. clr_err=1 -> underflow=0. clr_err and r_en on the same empty edge -> underflow=1.
5. Wrap-around: 3 rounds of 10 writes then 10 reads, data 0..29 -> reads return 0..29 in order; empty=1 and level=0 after each round.
6. Reset mid-operation: level=7, drop rst_n between edges -> empty=1, level=0 before the next edge. After release, write 0xA5 then read -> r_data=0xA5; no stale words returned. Repeat scenarios 2 and 5 with SYNC_FIFO_FWFT_EN, checking head visible with 0-cycle latency.
